// File: rtl/excess3_serial_decoder.sv
// Bit-serial excess-3 to BCD decoder: subtracts 0011 LSB-first with a borrow-tracking FSM,
// emits each result bit serially and the completed digit in parallel on A..D.
module excess3_serial_decoder (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_bit,
    input  logic in_first,
    output logic out_valid,
    output logic out_bit,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic digit_valid,
    output logic err
);

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B1_0 = 3'd1,
        B1_1 = 3'd2,
        B2_0 = 3'd3,
        B2_1 = 3'd4,
        B3_0 = 3'd5,
        B3_1 = 3'd6
    } state_t;

    state_t               state;
    state_t               eff_state;
    state_t               next_state;
    logic   [1:0]         pos;
    logic                 borrow_in;
    logic                 borrow_out;
    logic                 res_bit;
    logic   [2:0]         res;
    logic   [DIGIT_W-1:0] digit;

    // in_first restarts framing from any state, so decode against an effective state
    always_comb begin
        eff_state = in_first ? IDLE : state;
        pos       = 2'd0;
        borrow_in = 1'b0;
        case (eff_state)
            B1_0:    begin pos = 2'd1; borrow_in = 1'b0; end
            B1_1:    begin pos = 2'd1; borrow_in = 1'b1; end
            B2_0:    begin pos = 2'd2; borrow_in = 1'b0; end
            B2_1:    begin pos = 2'd2; borrow_in = 1'b1; end
            B3_0:    begin pos = 2'd3; borrow_in = 1'b0; end
            B3_1:    begin pos = 2'd3; borrow_in = 1'b1; end
            default: begin pos = 2'd0; borrow_in = 1'b0; end
        endcase
    end

    // One full-subtractor step against the constant 0011
    always_comb begin
        res_bit    = 1'b0;
        borrow_out = 1'b0;
        next_state = IDLE;
        case (pos)
            2'd0: begin
                res_bit    = ~in_bit;
                borrow_out = ~in_bit;
                next_state = borrow_out ? B1_1 : B1_0;
            end
            2'd1: begin
                res_bit    = ~(in_bit ^ borrow_in);
                borrow_out = ~in_bit | borrow_in;
                next_state = borrow_out ? B2_1 : B2_0;
            end
            2'd2: begin
                res_bit    = in_bit ^ borrow_in;
                borrow_out = ~in_bit & borrow_in;
                next_state = borrow_out ? B3_1 : B3_0;
            end
            default: begin
                res_bit    = in_bit ^ borrow_in;
                borrow_out = ~in_bit & borrow_in;
                next_state = IDLE;
            end
        endcase
        digit = {res_bit, res};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            res         <= 3'd0;
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
            A           <= 1'b0;
            B           <= 1'b0;
            C           <= 1'b0;
            D           <= 1'b0;
            digit_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            out_valid   <= in_valid;
            digit_valid <= 1'b0;
            err         <= 1'b0;
            if (in_valid) begin
                state   <= next_state;
                out_bit <= res_bit;
                case (pos)
                    2'd0: res[0] <= res_bit;
                    2'd1: res[1] <= res_bit;
                    2'd2: res[2] <= res_bit;
                    default: begin
                        digit_valid <= 1'b1;
                        // Final borrow means code < 3; result > 9 means code > 12
                        if (borrow_out || (digit > 4'd9)) begin
                            err          <= 1'b1;
                            {A, B, C, D} <= 4'b0000;
                        end else begin
                            {A, B, C, D} <= digit;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_excess3_serial_decoder.sv
// Randomized and directed bench for excess3_serial_decoder against an arithmetic reference model.
module tb_excess3_serial_decoder;

    logic clk = 1'b0;
    logic rst, in_valid, in_bit, in_first;
    logic out_valid, out_bit, A, B, C, D, digit_valid, err;

    excess3_serial_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_first(in_first),
        .out_valid(out_valid), .out_bit(out_bit), .A(A), .B(B), .C(C), .D(D),
        .digit_valid(digit_valid), .err(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [4:0] dig_q[$];
    logic       ob_q[$];
    int         dvc_q[$];

    // Reference model state: bits gathered so far of the current digit
    int         cnt;
    logic [3:0] x;
    int         low;
    bit         started = 1'b0;
    logic       e_ov, e_ob, e_dv, e_err;
    logic [3:0] e_abcd;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Model: out bit i is bit i of (low i+1 bits of code) - 3; digit = code - 3 when 3..12
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            started = 1'b1;
            cnt = 0; x = 4'd0;
            e_ov = 1'b0; e_ob = 1'b0; e_dv = 1'b0; e_err = 1'b0; e_abcd = 4'd0;
        end else if (started) begin
            e_ov = 1'b0; e_dv = 1'b0; e_err = 1'b0;
            if (in_valid) begin
                if (in_first) begin cnt = 0; x = 4'd0; end
                x[cnt[1:0]] = in_bit;
                low  = int'(x) & ((1 << (cnt + 1)) - 1);
                e_ob = 1'(((low + 16 - 3) >> cnt) & 1);
                e_ov = 1'b1;
                if (cnt == 3) begin
                    e_dv   = 1'b1;
                    e_err  = (x < 4'd3) || (x > 4'd12);
                    e_abcd = e_err ? 4'd0 : 4'(x - 4'd3);
                    cnt = 0; x = 4'd0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", int'(out_valid), int'(e_ov));
            if (e_ov) chk("out_bit", int'(out_bit), int'(e_ob));
            chk("digit_valid", int'(digit_valid), int'(e_dv));
            chk("err", int'(err), int'(e_err));
            chk("abcd", int'({A, B, C, D}), int'(e_abcd));
            if (out_valid) ob_q.push_back(out_bit);
            if (digit_valid) begin
                dig_q.push_back({err, A, B, C, D});
                dvc_q.push_back(cyc);
            end
        end
    end

    task automatic drive(input logic b, input logic f);
        @(negedge clk);
        in_valid = 1'b1; in_bit = b; in_first = f;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; in_bit = 1'($urandom); in_first = 1'($urandom);
        end
    endtask

    task automatic send_digit(input logic [3:0] code, input bit first, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            if (maxgap > 0) gap(int'($urandom_range(maxgap, 0)));
            drive(code[i], first && (i == 0));
        end
    endtask

    task automatic settle();
        gap(2);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        dig_q.delete(); ob_q.delete(); dvc_q.delete();
    endtask

    function automatic int dq(input int i);
        return (dig_q.size() > i) ? int'(dig_q[i]) : -1;
    endfunction

    function automatic int ob_packed();
        int v = 0;
        foreach (ob_q[i]) if (i < 4) v |= int'(ob_q[i]) << i;
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_first = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({out_valid, out_bit, A, B, C, D, digit_valid, err}), 0);
        rst = 1'b0;

        // Reset mid-digit must leave no stale borrow
        clear_logs();
        drive(1'b0, 1'b1); drive(1'b0, 1'b0);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        send_digit(4'b0111, 1'b0, 0);
        settle();
        chk("rst_mid_count", dig_q.size(), 1);
        chk("rst_mid_digit", dq(0), 5'b00100);

        // Code 0111 -> out bits 0,0,1,0 and digit 4
        clear_logs();
        send_digit(4'b0111, 1'b1, 0);
        settle();
        chk("c7_obcount", ob_q.size(), 4);
        chk("c7_obits", ob_packed(), 4'b0100);
        chk("c7_digit", dq(0), 5'b00100);

        // Full valid sweep back-to-back
        clear_logs();
        for (int c = 3; c <= 12; c++) send_digit(4'(c), 1'b1, 0);
        settle();
        chk("sweep_count", dig_q.size(), 10);
        for (int i = 0; i < 10; i++) chk("sweep_digit", dq(i), i);
        for (int i = 1; i < 10 && i < dvc_q.size(); i++)
            chk("sweep_spacing", dvc_q[i] - dvc_q[i-1], 4);

        // Invalid codes all flag err with zero digit
        begin
            logic [3:0] bad [4];
            bad = '{4'd2, 4'd13, 4'd0, 4'd15};
            foreach (bad[k]) begin
                clear_logs();
                send_digit(bad[k], 1'b1, 0);
                settle();
                chk("invalid_code", dq(0), 5'b10000);
            end
        end

        // Stall: 1100 with random gaps
        clear_logs();
        send_digit(4'b1100, 1'b1, 5);
        settle();
        chk("stall_obcount", ob_q.size(), 4);
        chk("stall_obits", ob_packed(), 4'b1001);
        chk("stall_digit", dq(0), 5'b01001);

        // Resync: partial digit discarded, 0101 -> 0010
        clear_logs();
        drive(1'b1, 1'b1); drive(1'b1, 1'b0);
        send_digit(4'b0101, 1'b1, 0);
        settle();
        chk("resync_count", dig_q.size(), 1);
        chk("resync_digit", dq(0), 5'b00010);

        // Random traffic with resyncs, gaps and resets
        repeat (500) begin
            int r;
            r = int'($urandom_range(99, 0));
            if (r < 3) begin
                @(negedge clk); rst = 1'b1; in_valid = 1'($urandom); in_first = 1'($urandom);
                @(negedge clk); rst = 1'b0; in_valid = 1'b0;
            end else if (r < 30) begin
                gap(1);
            end else begin
                drive(1'($urandom), ($urandom_range(9, 0) == 0));
            end
        end
        settle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
